// File: rtl/fetch_pkg.sv
// Shared opcodes, PC_select encodings and sequencer state encoding.
// Imported by the sequencer top and its branch decoder.
package fetch_pkg;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JR   = 6'h08;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [1:0] SEL_RA  = 2'd0;
    localparam logic [1:0] SEL_INC = 2'd1;
    localparam logic [1:0] SEL_ABS = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_sequencer_branch_decide.sv
// Maps (opcode, zero flag) to next-PC source selection and a halt flag.
// Purely combinational; no latency, no flow control.
module branch_decide
    import fetch_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [1:0] pc_select,
    output logic       inc_select,
    output logic       is_halt
);

    always_comb begin
        pc_select  = SEL_INC;
        inc_select = 1'b0;
        is_halt    = 1'b0;
        case (opcode)
            OP_BEQ:  inc_select = zero;
            OP_BNE:  inc_select = ~zero;
            OP_J:    pc_select  = SEL_ABS;
            OP_JR:   pc_select  = SEL_RA;
            OP_HALT: is_halt    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: holds IR, handshakes with the datapath, drives the PC generator.
// Instruction period MEM_LAT+2 cycles minimum; stalls in EXEC until Ex_done, HALT is sticky.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int RET_W   = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      Instr,
    input  logic             Ex_done,
    input  logic             Zero,
    output logic [31:0]      IR,
    output logic             IR_valid,
    output logic             Ex_start,
    output logic [1:0]       PC_select,
    output logic             INC_select,
    output logic             PC_enable,
    output logic             Halted,
    output logic [RET_W-1:0] Retired
);

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt, wait_cnt_nxt;
    logic [31:0]        ir_nxt;
    logic               ir_valid_nxt, ex_start_nxt, inc_nxt, pc_en_nxt, halted_nxt;
    logic [1:0]         pc_sel_nxt;
    logic [RET_W-1:0]   retired_nxt;

    logic [5:0]         dec_opcode;
    logic [1:0]         dec_pc_select;
    logic               dec_inc_select;
    logic               dec_is_halt;

    // FETCH decodes the word arriving from memory (for HALT); EXEC decodes the held IR.
    assign dec_opcode = (state == ST_FETCH) ? opcode_of(Instr) : opcode_of(IR);

    branch_decide u_decide (
        .opcode     (dec_opcode),
        .zero       (Zero),
        .pc_select  (dec_pc_select),
        .inc_select (dec_inc_select),
        .is_halt    (dec_is_halt)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ir_nxt       = IR;
        ir_valid_nxt = IR_valid;
        ex_start_nxt = 1'b0;
        pc_sel_nxt   = PC_select;
        inc_nxt      = INC_select;
        pc_en_nxt    = 1'b0;
        halted_nxt   = Halted;
        retired_nxt  = Retired;
        case (state)
            ST_FETCH: begin
                if (wait_cnt == LAST_WAIT) begin
                    ir_nxt       = Instr;
                    ir_valid_nxt = 1'b1;
                    wait_cnt_nxt = 4'd0;
                    if (dec_is_halt) begin
                        state_nxt  = ST_HALT;
                        halted_nxt = 1'b1;
                    end else begin
                        state_nxt    = ST_EXEC;
                        ex_start_nxt = 1'b1;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            ST_EXEC: begin
                if (Ex_done) begin
                    pc_sel_nxt = dec_pc_select;
                    inc_nxt    = dec_inc_select;
                    pc_en_nxt  = 1'b1;
                    state_nxt  = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                retired_nxt  = Retired + 1'b1;
                wait_cnt_nxt = 4'd0;
                state_nxt    = ST_FETCH;
            end
            default: halted_nxt = 1'b1;
        endcase
    end

    // Every output is a flop so nothing combinational reaches the pins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            IR         <= 32'd0;
            IR_valid   <= 1'b0;
            Ex_start   <= 1'b0;
            PC_select  <= SEL_INC;
            INC_select <= 1'b0;
            PC_enable  <= 1'b0;
            Halted     <= 1'b0;
            Retired    <= '0;
        end else begin
            IR         <= ir_nxt;
            IR_valid   <= ir_valid_nxt;
            Ex_start   <= ex_start_nxt;
            PC_select  <= pc_sel_nxt;
            INC_select <= inc_nxt;
            PC_enable  <= pc_en_nxt;
            Halted     <= halted_nxt;
            Retired    <= retired_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: stimulus pushes expected UPDATE decisions, a negedge monitor checks each PC_enable.
module tb_fetch_sequencer;

    typedef struct {
        logic [1:0]  sel;
        logic        inc;
        logic [31:0] ir;
        logic [15:0] ret;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance with MEM_LAT=1 and a 4-bit counter so wrap is reachable quickly.
    logic        rst1 = 1'b1, ex_done1 = 1'b0, zero1 = 1'b0;
    logic [31:0] instr1 = 32'd0;
    logic [31:0] ir1;
    logic        ir_valid1, ex_start1, inc1, pc_en1, halted1;
    logic [1:0]  sel1;
    logic [3:0]  ret1;

    fetch_sequencer #(.MEM_LAT(1), .RET_W(4)) dut1 (
        .Clock(clk), .Reset(rst1), .Instr(instr1), .Ex_done(ex_done1), .Zero(zero1),
        .IR(ir1), .IR_valid(ir_valid1), .Ex_start(ex_start1), .PC_select(sel1),
        .INC_select(inc1), .PC_enable(pc_en1), .Halted(halted1), .Retired(ret1)
    );

    logic        rst3 = 1'b1, ex_done3 = 1'b0, zero3 = 1'b0;
    logic [31:0] instr3 = 32'd0;
    logic [31:0] ir3;
    logic        ir_valid3, ex_start3, inc3, pc_en3, halted3;
    logic [1:0]  sel3;
    logic [15:0] ret3;

    fetch_sequencer #(.MEM_LAT(3), .RET_W(16)) dut3 (
        .Clock(clk), .Reset(rst3), .Instr(instr3), .Ex_done(ex_done3), .Zero(zero3),
        .IR(ir3), .IR_valid(ir_valid3), .Ex_start(ex_start3), .PC_select(sel3),
        .INC_select(inc3), .PC_enable(pc_en3), .Halted(halted3), .Retired(ret3)
    );

    exp_t q1[$];
    exp_t q3[$];
    int   n1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every PC_enable pulse must match the oldest outstanding expectation.
    logic prev_en1 = 1'b0, prev_en3 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (pc_en1) begin
            check("dut1 pc_enable single cycle", {31'd0, prev_en1}, 32'd0);
            if (q1.size() == 0) begin
                check("dut1 unexpected pc_enable", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1 PC_select", {30'd0, sel1}, {30'd0, e.sel});
                check("dut1 INC_select", {31'd0, inc1}, {31'd0, e.inc});
                check("dut1 IR", ir1, e.ir);
                check("dut1 Retired", {28'd0, ret1}, {28'd0, e.ret[3:0]});
            end
        end
        if (pc_en3) begin
            check("dut3 pc_enable single cycle", {31'd0, prev_en3}, 32'd0);
            if (q3.size() == 0) begin
                check("dut3 unexpected pc_enable", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                check("dut3 PC_select", {30'd0, sel3}, {30'd0, e.sel});
                check("dut3 INC_select", {31'd0, inc3}, {31'd0, e.inc});
                check("dut3 IR", ir3, e.ir);
                check("dut3 Retired", {16'd0, ret3}, {16'd0, e.ret});
            end
        end
        prev_en1 = pc_en1;
        prev_en3 = pc_en3;
    end

    task automatic check_reset1(input string tag);
        check({tag, " IR"}, ir1, 32'd0);
        check({tag, " IR_valid"}, {31'd0, ir_valid1}, 32'd0);
        check({tag, " Ex_start"}, {31'd0, ex_start1}, 32'd0);
        check({tag, " PC_select"}, {30'd0, sel1}, 32'd1);
        check({tag, " INC_select"}, {31'd0, inc1}, 32'd0);
        check({tag, " PC_enable"}, {31'd0, pc_en1}, 32'd0);
        check({tag, " Halted"}, {31'd0, halted1}, 32'd0);
        check({tag, " Retired"}, {28'd0, ret1}, 32'd0);
    endtask

    // Present one instruction to dut1, record its expected decision, wait for its PC_enable.
    task automatic issue(input logic [5:0] op, input logic z, input logic [1:0] sel,
                         input logic inc, output int gap);
        exp_t e;
        instr1 = {op, 26'(n1 * 5 + 1)};
        zero1  = z;
        e.sel = sel; e.inc = inc; e.ir = instr1; e.ret = 16'(n1);
        q1.push_back(e);
        n1++;
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (pc_en1) return;
        end
        check("dut1 pc_enable timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   gap;
        logic [3:0] ret_at_halt;
        int   pulses;

        // Reset values.
        repeat (2) @(negedge clk);
        check_reset1("reset");

        // Reset landing on the cycle Ex_done is accepted: no UPDATE, no pulse.
        instr1 = 32'h0000_0011;
        ex_done1 = 1'b1;
        rst1 = 1'b0;
        @(negedge clk);
        check("midreset Ex_start", {31'd0, ex_start1}, 32'd1);
        rst1 = 1'b1;
        @(negedge clk);
        check("midreset PC_enable", {31'd0, pc_en1}, 32'd0);
        check("midreset Retired", {28'd0, ret1}, 32'd0);
        @(negedge clk);
        check_reset1("midreset");

        // Sequential stream, Ex_done tied high: one commit every 3 cycles.
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(6'h00, 1'b0, 2'd1, 1'b0, gap);
            if (i == 0) check("seq first latency", gap, 2);
            else        check("seq period", gap, 3);
        end
        @(negedge clk);
        check("Retired after 12 cycles", {28'd0, ret1}, 32'd4);

        // Branch and jump decisions.
        issue(6'h04, 1'b1, 2'd1, 1'b1, gap);   // BEQ taken
        issue(6'h04, 1'b0, 2'd1, 1'b0, gap);   // BEQ not taken
        issue(6'h05, 1'b0, 2'd1, 1'b1, gap);   // BNE taken
        issue(6'h05, 1'b1, 2'd1, 1'b0, gap);   // BNE not taken
        issue(6'h02, 1'b0, 2'd2, 1'b0, gap);   // J
        issue(6'h08, 1'b1, 2'd0, 1'b0, gap);   // JR
        issue(6'h3E, 1'b1, 2'd1, 1'b0, gap);   // unknown opcode is sequential

        // Run past 16 commits so the 4-bit counter wraps to 0.
        while (n1 < 17) issue(6'h00, 1'b0, 2'd1, 1'b0, gap);
        ret_at_halt = 4'(n1);

        // HALT: sticky, no further commits despite Ex_done activity.
        instr1 = {6'h3F, 26'h0ABCDE};
        for (int i = 0; i < 10 && !halted1; i++) @(negedge clk);
        check("Halted set", {31'd0, halted1}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            ex_done1 = ~ex_done1;
            @(negedge clk);
            if (pc_en1) pulses++;
        end
        check("halt no pc_enable", pulses, 0);
        check("halt sticky", {31'd0, halted1}, 32'd1);
        check("halt Retired", {28'd0, ret1}, {28'd0, ret_at_halt});
        check("halt IR", ir1, {6'h3F, 26'h0ABCDE});
        check("halt IR_valid", {31'd0, ir_valid1}, 32'd1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check_reset1("post-halt reset");
        rst1 = 1'b1;

        // MEM_LAT=3 with Ex_done delayed 5 cycles past Ex_start.
        begin
            exp_t e;
            instr3 = {6'h04, 26'h0001234};
            zero3  = 1'b1;
            check("dut3 reset Retired", {16'd0, ret3}, 32'd0);
            e.sel = 2'd1; e.inc = 1'b1; e.ir = instr3; e.ret = 16'd0;
            q3.push_back(e);
            rst3 = 1'b0;
            @(negedge clk);
            check("dut3 IR_valid fetch1", {31'd0, ir_valid3}, 32'd0);
            @(negedge clk);
            check("dut3 IR_valid fetch2", {31'd0, ir_valid3}, 32'd0);
            @(negedge clk);
            check("dut3 IR loaded", ir3, {6'h04, 26'h0001234});
            check("dut3 IR_valid", {31'd0, ir_valid3}, 32'd1);
            check("dut3 Ex_start", {31'd0, ex_start3}, 32'd1);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                check("dut3 Ex_start pulse", {31'd0, ex_start3}, 32'd0);
                check("dut3 early pc_enable", {31'd0, pc_en3}, 32'd0);
            end
            ex_done3 = 1'b1;
            @(negedge clk);
            ex_done3 = 1'b0;
            check("dut3 pc_enable after Ex_done", {31'd0, pc_en3}, 32'd1);
            @(negedge clk);
            check("dut3 pc_enable drop", {31'd0, pc_en3}, 32'd0);
            check("dut3 Retired", {16'd0, ret3}, 32'd1);
            rst3 = 1'b1;
        end

        repeat (3) @(negedge clk);
        check("dut1 scoreboard drained", q1.size(), 0);
        check("dut3 scoreboard drained", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
